// File: rtl/stoch_mac_if.sv
// Job handshake and operand/result bundle for the stochastic MAC engine.
// The master side issues jobs; the slave side is the MAC datapath.
interface stoch_mac_if #(
  parameter int W     = 4,
  parameter int ACC_W = 2*W+4
);
  logic             start;
  logic [W-1:0]     a_bin;
  logic [W-1:0]     b_bin;
  logic [W-1:0]     c_bin;
  logic             add_en;
  logic             acc_clr;
  logic             ready;
  logic             done;
  logic             sn_out;
  logic [ACC_W-1:0] result;
  logic             sat;

  modport master (
    output start, a_bin, b_bin, c_bin, add_en, acc_clr,
    input  ready, done, sn_out, result, sat
  );

  modport slave (
    input  start, a_bin, b_bin, c_bin, add_en, acc_clr,
    output ready, done, sn_out, result, sat
  );
endinterface

// File: rtl/stoch_mac_seq.sv
// Self-sequenced stochastic multiply-accumulate: counter-compare unary streams with
// clock-division (lo/hi halves of k) give an exact a*b, optionally plus c*2^W.
module stoch_mac_seq #(
  parameter int W     = 4,
  parameter int ACC_W = 2*W+4
) (
  input  logic      clk,
  input  logic      rst_n,
  stoch_mac_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROD = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2*W-1:0] K_ONE = {{(2*W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [2*W-1:0]   k;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     c_q;
  logic             add_en_q;
  logic [ACC_W-1:0] result_q;
  logic             sat_q;
  logic             ready_q;
  logic             done_q;

  logic [W-1:0]     lo;
  logic [W-1:0]     hi;
  logic             sn;
  logic [ACC_W:0]   inc;

  // Returns {overflow, next}; the value pins at all-ones instead of wrapping.
  function automatic logic [ACC_W:0] sat_inc(input logic [ACC_W-1:0] v);
    logic [ACC_W-1:0] nxt;
    if (&v) begin
      return {1'b1, v};
    end
    nxt = v + {{(ACC_W-1){1'b0}}, 1'b1};
    return {1'b0, nxt};
  endfunction

  assign lo = k[W-1:0];
  assign hi = k[2*W-1:W];

  // a compares against the fast half of k and b against the slow half, so the
  // two streams are decorrelated by construction and the AND counts exactly a*b.
  always_comb begin
    sn = 1'b0;
    case (state)
      PROD:    sn = (a_q > lo) && (b_q > hi);
      ADD:     sn = (c_q > hi);
      default: sn = 1'b0;
    endcase
  end

  assign inc = sat_inc(result_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      add_en_q <= 1'b0;
      result_q <= '0;
      sat_q    <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q      <= bus.a_bin;
            b_q      <= bus.b_bin;
            c_q      <= bus.c_bin;
            add_en_q <= bus.add_en;
            if (bus.acc_clr) begin
              result_q <= '0;
              sat_q    <= 1'b0;
            end
            k       <= '0;
            ready_q <= 1'b0;
            state   <= PROD;
          end
        end
        PROD, ADD: begin
          if (sn) begin
            result_q <= inc[ACC_W-1:0];
            if (inc[ACC_W]) begin
              sat_q <= 1'b1;
            end
          end
          // k wraps to zero on its own at the phase boundary.
          k <= k + K_ONE;
          if (&k) begin
            if (state == PROD && add_en_q) begin
              state <= ADD;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.done   = done_q;
  assign bus.sn_out = sn;
  assign bus.result = result_q;
  assign bus.sat    = sat_q;

endmodule

// File: tb/tb_stoch_mac_seq.sv
// Directed bench for stoch_mac_seq: three configurations (W=4/ACC_W=12, W=4/ACC_W=9,
// W=2/ACC_W=6) share one stimulus bus and a select that routes start to one of them.
module tb_stoch_mac_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [1:0] sel;
  logic [3:0] a, b, c;
  logic       add_en, acc_clr;

  stoch_mac_if #(.W(4), .ACC_W(12)) if0 ();
  stoch_mac_if #(.W(4), .ACC_W(9))  if1 ();
  stoch_mac_if #(.W(2), .ACC_W(6))  if2 ();

  assign if0.start   = start && (sel == 2'd0);
  assign if0.a_bin   = a;
  assign if0.b_bin   = b;
  assign if0.c_bin   = c;
  assign if0.add_en  = add_en;
  assign if0.acc_clr = acc_clr;

  assign if1.start   = start && (sel == 2'd1);
  assign if1.a_bin   = a;
  assign if1.b_bin   = b;
  assign if1.c_bin   = c;
  assign if1.add_en  = add_en;
  assign if1.acc_clr = acc_clr;

  assign if2.start   = start && (sel == 2'd2);
  assign if2.a_bin   = a[1:0];
  assign if2.b_bin   = b[1:0];
  assign if2.c_bin   = c[1:0];
  assign if2.add_en  = add_en;
  assign if2.acc_clr = acc_clr;

  stoch_mac_seq #(.W(4), .ACC_W(12)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  stoch_mac_seq #(.W(4), .ACC_W(9))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  stoch_mac_seq #(.W(2), .ACC_W(6))  dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  logic        rdy_s, done_s, sn_s, sat_s;
  logic [11:0] res_s;

  always_comb begin
    rdy_s  = if0.ready;
    done_s = if0.done;
    sn_s   = if0.sn_out;
    res_s  = if0.result;
    sat_s  = if0.sat;
    case (sel)
      2'd1: begin
        rdy_s  = if1.ready;
        done_s = if1.done;
        sn_s   = if1.sn_out;
        res_s  = 12'(if1.result);
        sat_s  = if1.sat;
      end
      2'd2: begin
        rdy_s  = if2.ready;
        done_s = if2.done;
        sn_s   = if2.sn_out;
        res_s  = 12'(if2.result);
        sat_s  = if2.sat;
      end
      default: ;
    endcase
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int sel;
    int a;
    int b;
    int c;
    int add;
    int clr;
    int res;
    int sat;
    int cyc;
    int ones;
  } vec_t;

  vec_t vt[$];

  // Waits for ready on the selected unit, then presents one start pulse.
  task automatic accept_job(input vec_t v, input string name);
    int t;
    @(negedge clk);
    sel = 2'(v.sel);
    #1;
    t = 0;
    while (!rdy_s && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!rdy_s) check({name, " ready-timeout"}, 0, 1);
    a       = 4'(v.a);
    b       = 4'(v.b);
    c       = 4'(v.c);
    add_en  = v.add[0];
    acc_clr = v.clr[0];
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble the bus; the captured copies must be what the engine uses.
    a       = ~a;
    b       = ~b;
    c       = ~c;
    add_en  = ~add_en;
    acc_clr = 1'b0;
  endtask

  task automatic run_job(input vec_t v, input int idx);
    string nm;
    int    cyc, ones, got;
    nm = $sformatf("job%0d", idx);
    accept_job(v, nm);
    cyc  = 0;
    ones = 0;
    got  = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (done_s) begin
        got = 1;
        break;
      end
      cyc++;
      ones += int'(sn_s);
    end
    check({nm, " done-seen"}, got, 1);
    check({nm, " cycles"}, cyc, v.cyc);
    check({nm, " ones"}, ones, v.ones);
    check({nm, " result"}, int'(res_s), v.res);
    check({nm, " sat"}, int'(sat_s), v.sat);
    @(negedge clk);
    check({nm, " ready-after"}, int'(rdy_s), 1);
    check({nm, " done-pulse-width"}, int'(done_s), 0);
  endtask

  initial begin
    vec_t v;
    int   done_cnt, done_at;

    // sel a  b  c  add clr res sat cyc ones
    vt.push_back('{0, 5, 3, 15, 0, 1, 15, 0, 256, 15});
    vt.push_back('{0, 15, 15, 15, 1, 1, 465, 0, 512, 465});
    vt.push_back('{0, 4, 4, 0, 0, 1, 16, 0, 256, 16});
    vt.push_back('{0, 4, 4, 0, 0, 0, 32, 0, 256, 16});
    vt.push_back('{0, 0, 15, 0, 0, 0, 32, 0, 256, 0});
    vt.push_back('{1, 15, 15, 15, 1, 1, 465, 0, 512, 465});
    vt.push_back('{1, 15, 15, 15, 1, 0, 511, 1, 512, 465});
    vt.push_back('{1, 1, 1, 0, 0, 1, 1, 0, 256, 1});
    for (int ai = 0; ai < 4; ai++)
      for (int bi = 0; bi < 4; bi++)
        vt.push_back('{2, ai, bi, 3, 0, 1, ai*bi, 0, 16, ai*bi});
    for (int ai = 0; ai < 4; ai++)
      for (int bi = 0; bi < 4; bi++)
        vt.push_back('{2, ai, bi, 3, 1, 1, ai*bi + 12, 0, 32, ai*bi + 12});

    rst_n   = 1'b0;
    start   = 1'b0;
    sel     = 2'd0;
    a       = '0;
    b       = '0;
    c       = '0;
    add_en  = 1'b0;
    acc_clr = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check($sformatf("reset%0d ready", s), int'(rdy_s), 1);
      check($sformatf("reset%0d done", s), int'(done_s), 0);
      check($sformatf("reset%0d sn_out", s), int'(sn_s), 0);
      check($sformatf("reset%0d result", s), int'(res_s), 0);
      check($sformatf("reset%0d sat", s), int'(sat_s), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) run_job(vt[i], i);

    // Starts issued while busy are dropped: one done, result from the first job only.
    v = '{0, 2, 3, 0, 0, 1, 6, 0, 256, 6};
    accept_job(v, "busy");
    done_cnt = 0;
    done_at  = -1;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (done_s) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (i == 10 || i == 100) begin
        a     = 4'd15;
        b     = 4'd15;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check("busy done-count", done_cnt, 1);
    check("busy done-cycle", done_at, 256);
    check("busy result", int'(res_s), 6);

    // Asynchronous reset in the middle of PROD aborts the job.
    v = '{0, 15, 15, 0, 0, 0, 0, 0, 0, 0};
    accept_job(v, "abort");
    repeat (40) @(negedge clk);
    check("abort pre-reset busy", int'(rdy_s), 0);
    rst_n = 1'b0;
    #1;
    check("abort ready", int'(rdy_s), 1);
    check("abort result", int'(res_s), 0);
    check("abort sat", int'(sat_s), 0);
    check("abort sn_out", int'(sn_s), 0);
    check("abort done", int'(done_s), 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done_s) done_cnt++;
    end
    check("abort no-done", done_cnt, 0);
    check("abort result-held", int'(res_s), 0);
    check("abort ready-held", int'(rdy_s), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
